// File: rtl/fc_init_ctrl.sv
// Flow-control initialisation sequencer for one virtual channel (InitFC1/InitFC2 handshake).
// Optional macro FC_SCALE_EN: forward rx scale fields and reject InitFC with scale 2'b11.
module fc_init_ctrl #(
  parameter logic [2:0]  VC_ID         = 3'd0,
  parameter int unsigned RESEND_CYCLES = 1700,
  parameter int unsigned TIMER_W       = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dl_enable,
  input  logic        rx_valid,
  input  logic        rx_init2,
  input  logic        rx_updatefc,
  input  logic [2:0]  rx_type,
  input  logic [2:0]  rx_vc,
  input  logic [1:0]  rx_hdr_scale,
  input  logic [1:0]  rx_data_scale,
  input  logic [7:0]  rx_hdr_fc,
  input  logic [11:0] rx_data_fc,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [1:0]  tx_type,
  output logic        tx_init2,
  output logic        cr_we,
  output logic [1:0]  cr_type,
  output logic [7:0]  cr_hdr_fc,
  output logic [11:0] cr_data_fc,
  output logic [1:0]  cr_hdr_scale,
  output logic [1:0]  cr_data_scale,
  output logic [1:0]  fc_state,
  output logic        fc_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT1 = 2'd1,
    INIT2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] RESEND_LAST = TIMER_W'(RESEND_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;

  state_t             state, state_d;
  logic               p_seen, np_seen, cpl_seen, fi2;
  logic               gap;
  logic [TIMER_W-1:0] timer;
  logic               scale_ok;
  logic               cls_clear;
  logic               cap_hit;
  logic               fi2_hit;

`ifdef FC_SCALE_EN
  assign scale_ok = (rx_hdr_scale != 2'b11) && (rx_data_scale != 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_hdr_scale  <= '0;
      cr_data_scale <= '0;
    end else if (cap_hit) begin
      cr_hdr_scale  <= rx_hdr_scale;
      cr_data_scale <= rx_data_scale;
    end
  end
`else
  logic unused_scale;
  assign unused_scale  = ^{rx_hdr_scale, rx_data_scale};
  assign scale_ok      = 1'b1;
  assign cr_hdr_scale  = '0;
  assign cr_data_scale = '0;
`endif

  always_comb begin
    cls_clear = 1'b0;
    case (rx_type)
      3'd0:    cls_clear = ~p_seen;
      3'd1:    cls_clear = ~np_seen;
      3'd2:    cls_clear = ~cpl_seen;
      default: cls_clear = 1'b0;
    endcase
  end

  assign cap_hit = dl_enable && (state == INIT1) && rx_valid && !rx_updatefc &&
                   (rx_vc == VC_ID) && cls_clear && scale_ok;
  assign fi2_hit = dl_enable && (state == INIT2) && rx_valid && (rx_vc == VC_ID) &&
                   (rx_init2 || rx_updatefc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Transitions only fire while gap is set, so an in-flight triplet always completes.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (dl_enable) state_d = INIT1;
      INIT1:   if (p_seen && np_seen && cpl_seen && gap) state_d = INIT2;
      INIT2:   if (fi2 && gap) state_d = DONE;
      default: state_d = state;
    endcase
    if (!dl_enable) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid   <= 1'b0;
      tx_type    <= '0;
      gap        <= 1'b0;
      timer      <= '0;
      p_seen     <= 1'b0;
      np_seen    <= 1'b0;
      cpl_seen   <= 1'b0;
      fi2        <= 1'b0;
      cr_we      <= 1'b0;
      cr_type    <= '0;
      cr_hdr_fc  <= '0;
      cr_data_fc <= '0;
    end else begin
      cr_we <= 1'b0;
      if (!dl_enable) begin
        tx_valid <= 1'b0;
        tx_type  <= '0;
        gap      <= 1'b0;
        timer    <= '0;
        p_seen   <= 1'b0;
        np_seen  <= 1'b0;
        cpl_seen <= 1'b0;
        fi2      <= 1'b0;
      end else if ((state == INIT1 || state == INIT2) && state_d == state) begin
        if (tx_valid) begin
          if (tx_ready) begin
            if (tx_type == 2'd2) begin
              tx_valid <= 1'b0;
              tx_type  <= '0;
              gap      <= 1'b1;
              timer    <= '0;
            end else begin
              tx_type <= tx_type + 2'd1;
            end
          end
        end else if (!gap || timer >= RESEND_LAST) begin
          tx_valid <= 1'b1;
          tx_type  <= '0;
          gap      <= 1'b0;
          timer    <= '0;
        end else if (timer != TIMER_MAX) begin
          timer <= timer + 1'b1;
        end
      end else begin
        tx_valid <= 1'b0;
        tx_type  <= '0;
        gap      <= 1'b0;
        timer    <= '0;
      end

      if (cap_hit) begin
        case (rx_type)
          3'd0:    p_seen   <= 1'b1;
          3'd1:    np_seen  <= 1'b1;
          default: cpl_seen <= 1'b1;
        endcase
        cr_we      <= 1'b1;
        cr_type    <= rx_type[1:0];
        cr_hdr_fc  <= rx_hdr_fc;
        cr_data_fc <= rx_data_fc;
      end
      if (fi2_hit) fi2 <= 1'b1;
    end
  end

  assign tx_init2 = (state == INIT2);
  assign fc_state = state;
  assign fc_done  = (state == DONE);

endmodule

// File: tb/tb_fc_init_ctrl.sv
// Directed bench for fc_init_ctrl: capture table in INIT1 plus hand-written handshake sequences.
module tb_fc_init_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl_enable, rx_valid, rx_init2, rx_updatefc;
  logic [2:0]  rx_type, rx_vc;
  logic [1:0]  rx_hdr_scale, rx_data_scale;
  logic [7:0]  rx_hdr_fc;
  logic [11:0] rx_data_fc;
  logic        tx_valid, tx_ready, tx_init2, cr_we, fc_done;
  logic [1:0]  tx_type, cr_type, cr_hdr_scale, cr_data_scale, fc_state;
  logic [7:0]  cr_hdr_fc;
  logic [11:0] cr_data_fc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fc_init_ctrl #(.VC_ID(3'd0), .RESEND_CYCLES(1700), .TIMER_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .dl_enable(dl_enable),
    .rx_valid(rx_valid), .rx_init2(rx_init2), .rx_updatefc(rx_updatefc),
    .rx_type(rx_type), .rx_vc(rx_vc), .rx_hdr_scale(rx_hdr_scale),
    .rx_data_scale(rx_data_scale), .rx_hdr_fc(rx_hdr_fc), .rx_data_fc(rx_data_fc),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_type(tx_type), .tx_init2(tx_init2),
    .cr_we(cr_we), .cr_type(cr_type), .cr_hdr_fc(cr_hdr_fc), .cr_data_fc(cr_data_fc),
    .cr_hdr_scale(cr_hdr_scale), .cr_data_scale(cr_data_scale),
    .fc_state(fc_state), .fc_done(fc_done)
  );

  typedef struct {
    logic        upd;
    logic        init2;
    logic [2:0]  typ;
    logic [2:0]  vc;
    logic [1:0]  hs;
    logic [1:0]  ds;
    logic [7:0]  hdr;
    logic [11:0] data;
    logic        exp_we;
    logic [1:0]  exp_type;
    logic [7:0]  exp_hdr;
    logic [11:0] exp_data;
    logic [1:0]  exp_hs;
    logic [1:0]  exp_ds;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic upd, input logic init2, input logic [2:0] typ,
                          input logic [2:0] vc, input logic [1:0] hs, input logic [1:0] ds,
                          input logic [7:0] hdr, input logic [11:0] data);
    rx_updatefc = upd; rx_init2 = init2; rx_type = typ; rx_vc = vc;
    rx_hdr_scale = hs; rx_data_scale = ds; rx_hdr_fc = hdr; rx_data_fc = data;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input string name, output int cnt);
    cnt = 0;
    while (!tx_valid && cnt < 3000) begin
      cnt++;
      step();
    end
    if (cnt >= 3000) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int cnt;
    //          upd init2 typ   vc    hs     ds     hdr    data     we  type  hdr    data     hs     ds
    vecs[0] = '{1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 2'b00, 8'h20, 12'h100, 1'b1, 2'd0, 8'h20, 12'h100, 2'b00, 2'b00};
    vecs[1] = '{1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 2'b00, 8'h55, 12'h155, 1'b0, 2'd0, 8'h20, 12'h100, 2'b00, 2'b00};
    vecs[2] = '{1'b0, 1'b0, 3'd1, 3'd1, 2'b00, 2'b00, 8'h33, 12'h133, 1'b0, 2'd0, 8'h20, 12'h100, 2'b00, 2'b00};
    vecs[3] = '{1'b0, 1'b0, 3'd7, 3'd0, 2'b00, 2'b00, 8'h44, 12'h144, 1'b0, 2'd0, 8'h20, 12'h100, 2'b00, 2'b00};
    vecs[4] = '{1'b1, 1'b0, 3'd1, 3'd0, 2'b00, 2'b00, 8'h66, 12'h166, 1'b0, 2'd0, 8'h20, 12'h100, 2'b00, 2'b00};
    vecs[5] = '{1'b0, 1'b1, 3'd1, 3'd0, 2'b00, 2'b00, 8'h21, 12'h101, 1'b1, 2'd1, 8'h21, 12'h101, 2'b00, 2'b00};
`ifdef FC_SCALE_EN
    vecs[6] = '{1'b0, 1'b0, 3'd2, 3'd0, 2'b11, 2'b00, 8'h77, 12'h177, 1'b0, 2'd1, 8'h21, 12'h101, 2'b00, 2'b00};
    vecs[7] = '{1'b0, 1'b0, 3'd2, 3'd0, 2'b01, 2'b10, 8'h22, 12'h102, 1'b1, 2'd2, 8'h22, 12'h102, 2'b01, 2'b10};
`else
    vecs[6] = '{1'b0, 1'b0, 3'd2, 3'd0, 2'b11, 2'b00, 8'h22, 12'h102, 1'b1, 2'd2, 8'h22, 12'h102, 2'b00, 2'b00};
    vecs[7] = '{1'b0, 1'b0, 3'd2, 3'd0, 2'b01, 2'b10, 8'h77, 12'h177, 1'b0, 2'd2, 8'h22, 12'h102, 2'b00, 2'b00};
`endif

    rst_n = 1'b0; dl_enable = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    rx_init2 = 1'b0; rx_updatefc = 1'b0; rx_type = '0; rx_vc = '0;
    rx_hdr_scale = '0; rx_data_scale = '0; rx_hdr_fc = '0; rx_data_fc = '0;
    repeat (3) step();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_state", fc_state, 0);
    check("rst_cr_we", cr_we, 0);
    check("rst_done", fc_done, 0);
    check("rst_cr_hdr", cr_hdr_fc, 0);
    rst_n = 1'b1;
    step();
    check("idle_hold", fc_state, 0);

    // First InitFC1 triplet and resend gap
    dl_enable = 1'b1; tx_ready = 1'b1;
    step();
    check("enter_init1", fc_state, 1);
    check("init1_first_no_tx", tx_valid, 0);
    step();
    check("t1_p_valid", tx_valid, 1);
    check("t1_p_type", tx_type, 0);
    check("t1_p_init2", tx_init2, 0);
    step();
    check("t1_np_type", tx_type, 1);
    step();
    check("t1_cpl_type", tx_type, 2);
    step();
    check("t1_after_cpl", tx_valid, 0);
    wait_tx("gap1", cnt);
    check("gap_len", cnt, 1700);
    check("t2_p_type", tx_type, 0);

    // Capture table, TX stalled so the triplet must not be truncated
    tx_ready = 1'b0;
    foreach (vecs[i]) begin
      pulse_rx(vecs[i].upd, vecs[i].init2, vecs[i].typ, vecs[i].vc, vecs[i].hs, vecs[i].ds,
               vecs[i].hdr, vecs[i].data);
      check($sformatf("vec%0d_we", i), cr_we, vecs[i].exp_we);
      check($sformatf("vec%0d_type", i), cr_type, vecs[i].exp_type);
      check($sformatf("vec%0d_hdr", i), cr_hdr_fc, vecs[i].exp_hdr);
      check($sformatf("vec%0d_data", i), cr_data_fc, vecs[i].exp_data);
      check($sformatf("vec%0d_hscale", i), cr_hdr_scale, vecs[i].exp_hs);
      check($sformatf("vec%0d_dscale", i), cr_data_scale, vecs[i].exp_ds);
    end
    step();
    check("stall_state_init1", fc_state, 1);
    check("stall_tx_valid", tx_valid, 1);
    check("stall_tx_type", tx_type, 0);
    tx_ready = 1'b1;
    step(); check("t2_np", tx_type, 1);
    step(); check("t2_cpl", tx_type, 2);
    step();
    check("t2_done_valid", tx_valid, 0);
    check("t2_done_state", fc_state, 1);
    step();
    check("enter_init2", fc_state, 2);
    check("init2_entry_no_tx", tx_valid, 0);
    step();
    check("i2_p_valid", tx_valid, 1);
    check("i2_p_init2", tx_init2, 1);
    check("i2_p_type", tx_type, 0);

    // INIT2 ignores InitFC1 and other VCs; no credit writes
    pulse_rx(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 2'b00, 8'h99, 12'h199);
    check("i2_initfc1_no_we", cr_we, 0);
    check("i2_np", tx_type, 1);
    pulse_rx(1'b0, 1'b1, 3'd0, 3'd1, 2'b00, 2'b00, 8'h98, 12'h198);
    check("i2_cpl", tx_type, 2);
    step();
    check("i2_cpl_acc", tx_valid, 0);
    step();
    check("i2_no_fi2_stay", fc_state, 2);
    wait_tx("gap2", cnt);
    check("i2_resend_type", tx_type, 0);
    check("i2_resend_init2", tx_init2, 1);

    // UpdateFC during a stalled triplet: DONE only after Cpl accepted
    tx_ready = 1'b0;
    pulse_rx(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 2'b00, 8'h11, 12'h011);
    check("upd_no_we", cr_we, 0);
    repeat (5) step();
    check("stall5_state", fc_state, 2);
    check("stall5_valid", tx_valid, 1);
    check("stall5_type", tx_type, 0);
    tx_ready = 1'b1;
    step(); check("i2b_np", tx_type, 1);
    step(); check("i2b_cpl", tx_type, 2);
    step();
    check("i2b_cpl_state", fc_state, 2);
    check("i2b_cpl_valid", tx_valid, 0);
    step();
    check("done_state", fc_state, 3);
    check("done_flag", fc_done, 1);
    check("done_no_tx", tx_valid, 0);
    pulse_rx(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 2'b00, 8'h99, 12'h199);
    check("done_no_we", cr_we, 0);
    check("done_hdr_kept", cr_hdr_fc, 8'h22);
    check("done_hold", fc_state, 3);

    // Disable from DONE, re-run to INIT2, then drop mid-triplet
    dl_enable = 1'b0;
    step();
    check("dis_idle", fc_state, 0);
    check("dis_done_clr", fc_done, 0);
    dl_enable = 1'b1;
    step(); check("re_init1", fc_state, 1);
    step();
    check("re_p_valid", tx_valid, 1);
    check("re_p_init2", tx_init2, 0);
    tx_ready = 1'b0;
    pulse_rx(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 2'b00, 8'h30, 12'h130);
    check("re_cap_p_we", cr_we, 1);
    check("re_cap_p_hdr", cr_hdr_fc, 8'h30);
    pulse_rx(1'b0, 1'b0, 3'd1, 3'd0, 2'b00, 2'b00, 8'h31, 12'h131);
    check("re_cap_np_we", cr_we, 1);
    pulse_rx(1'b0, 1'b0, 3'd2, 3'd0, 2'b00, 2'b00, 8'h32, 12'h132);
    check("re_cap_cpl_data", cr_data_fc, 12'h132);
    tx_ready = 1'b1;
    repeat (3) step();
    step(); check("re_init2", fc_state, 2);
    step(); check("re_i2_p", tx_valid, 1);
    step(); check("re_i2_np", tx_type, 1);
    tx_ready = 1'b0;
    dl_enable = 1'b0;
    pulse_rx(1'b0, 1'b1, 3'd0, 3'd0, 2'b00, 2'b00, 8'h40, 12'h140);
    check("drop_idle", fc_state, 0);
    check("drop_no_tx", tx_valid, 0);
    check("drop_no_we", cr_we, 0);
    dl_enable = 1'b1;
    step(); check("restart_init1", fc_state, 1);
    step();
    check("restart_valid", tx_valid, 1);
    check("restart_type", tx_type, 0);
    check("restart_init2", tx_init2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
